// File: rtl/cv32e40p_rf_pkg.sv
// cv32e40p_rf_pkg: shared types and sizing helpers for the multi-port register file.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cv32e40p_rf_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      DONE  = 2'd2
   } clr_state_e;

   localparam int NUM_INT_WORDS = 32;
   localparam int NUM_FP_WORDS  = 32;

   // The FP bank only exists when an FPU is present and FP values are not
   // carried in the integer registers (Zfinx).
   function automatic int rf_num_tot(input int fpu, input int pulp_zfinx);
      return (fpu == 1 && pulp_zfinx == 0) ? (NUM_INT_WORDS + NUM_FP_WORDS) : NUM_INT_WORDS;
   endfunction

endpackage

// File: rtl/cv32e40p_regfile_mp_if.sv
// cv32e40p_regfile_mp_if: bundle of read/write/scoreboard/clear signals of the register file.
// Latency: n/a (wires only).
// Backpressure: none; master drives requests, slave returns data/status.
interface cv32e40p_regfile_mp_if #(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_RPORTS = 3,
   parameter int NUM_WPORTS = 2
);
   logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr_i;
   logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata_o;
   logic [NUM_RPORTS-1:0]            rbusy_o;
   logic [NUM_WPORTS*ADDR_WIDTH-1:0] waddr_i;
   logic [NUM_WPORTS*DATA_WIDTH-1:0] wdata_i;
   logic [NUM_WPORTS-1:0]            we_i;
   logic                             alloc_i;
   logic [ADDR_WIDTH-1:0]            alloc_addr_i;
   logic                             clr_req_i;
   logic                             clr_busy_o;
   logic                             clr_done_o;

   modport master (
      output raddr_i, waddr_i, wdata_i, we_i, alloc_i, alloc_addr_i, clr_req_i,
      input  rdata_o, rbusy_o, clr_busy_o, clr_done_o
   );

   modport slave (
      input  raddr_i, waddr_i, wdata_i, we_i, alloc_i, alloc_addr_i, clr_req_i,
      output rdata_o, rbusy_o, clr_busy_o, clr_done_o
   );
endinterface

// File: rtl/cv32e40p_rf_scoreboard.sv
// cv32e40p_rf_scoreboard: per-register pending bits for long-latency producers.
// Latency: alloc/write/clear update pending at the next edge; rbusy is combinational.
// Backpressure: none; callers pre-gate alloc/write strobes while a clear runs.
// Ports: wr_dec (per-register committed-write strobe), alloc_vld/alloc_idx,
//        clr_stb/clr_idx (bulk-clear index), byp_en, rd_idx/rd_ok per read port, rbusy.
module cv32e40p_rf_scoreboard #(
   parameter int NUM_TOT    = 64,
   parameter int NUM_RPORTS = 3,
   parameter int IDX_W      = $clog2(NUM_TOT)
)(
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_TOT-1:0]               wr_dec,
   input  logic                             alloc_vld,
   input  logic [IDX_W-1:0]                 alloc_idx,
   input  logic                             clr_stb,
   input  logic [IDX_W-1:0]                 clr_idx,
   input  logic                             byp_en,
   input  logic [NUM_RPORTS-1:0][IDX_W-1:0] rd_idx,
   input  logic [NUM_RPORTS-1:0]            rd_ok,
   output logic [NUM_RPORTS-1:0]            rbusy
);

   logic [NUM_TOT-1:0] pending_q;

   // Clear beats alloc; alloc beats a same-cycle write so the newest
   // producer keeps the register marked.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending_q <= '0;
      end else begin
         for (int r = 0; r < NUM_TOT; r++) begin
            if (clr_stb && clr_idx == IDX_W'(r)) begin
               pending_q[r] <= 1'b0;
            end else if (alloc_vld && alloc_idx == IDX_W'(r)) begin
               pending_q[r] <= 1'b1;
            end else if (wr_dec[r]) begin
               pending_q[r] <= 1'b0;
            end
         end
      end
   end

   // A write landing this cycle satisfies the reader through the bypass,
   // unless a new producer is claiming the same register.
   always_comb begin
      rbusy = '0;
      for (int k = 0; k < NUM_RPORTS; k++) begin
         rbusy[k] = rd_ok[k] && pending_q[rd_idx[k]] &&
                    !(byp_en && wr_dec[rd_idx[k]] && !(alloc_vld && alloc_idx == rd_idx[k]));
      end
   end

endmodule

// File: rtl/cv32e40p_regfile_mp.sv
// cv32e40p_regfile_mp: flip-flop register file (int + optional FP bank), pending scoreboard, bulk clear.
// Latency: reads combinational with optional same-cycle write bypass; writes commit at posedge.
// Backpressure: none; writes/allocs are dropped while clr_busy_o is high (clear takes NUM_TOT+1 cycles).
// Ports: clk, rst_n (async active-low), rf (slave side of cv32e40p_regfile_mp_if).
module cv32e40p_regfile_mp
   import cv32e40p_rf_pkg::*;
#(
   parameter int ADDR_WIDTH = 6,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_RPORTS = 3,
   parameter int NUM_WPORTS = 2,
   parameter int FPU        = 0,
   parameter int PULP_ZFINX = 0,
   parameter int BYPASS     = 1
)(
   input  logic                 clk,
   input  logic                 rst_n,
   cv32e40p_regfile_mp_if.slave rf
);

   localparam int NUM_TOT = rf_num_tot(FPU, PULP_ZFINX);
   localparam bit HAS_FP  = (NUM_TOT > NUM_INT_WORDS);
   localparam int IDX_W   = $clog2(NUM_TOT);

   logic [NUM_RPORTS-1:0][ADDR_WIDTH-1:0] raddr;
   logic [NUM_RPORTS-1:0][DATA_WIDTH-1:0] rdata;
   logic [NUM_RPORTS-1:0][IDX_W-1:0]      rd_idx;
   logic [NUM_RPORTS-1:0]                 rd_ok;
   logic [NUM_WPORTS-1:0][ADDR_WIDTH-1:0] waddr;
   logic [NUM_WPORTS-1:0][DATA_WIDTH-1:0] wdata;
   logic [NUM_TOT-1:0]                    wr_dec;
   logic [NUM_TOT-1:0][DATA_WIDTH-1:0]    wr_dat;
   logic [DATA_WIDTH-1:0]                 mem [NUM_TOT];
   clr_state_e                            state_q, state_d;
   logic [IDX_W-1:0]                      cnt_q, cnt_d;
   logic                                  clr_stb, busy, done;
   logic                                  alloc_vld, byp_en;

   assign raddr         = rf.raddr_i;
   assign waddr         = rf.waddr_i;
   assign wdata         = rf.wdata_i;
   assign rf.rdata_o    = rdata;
   assign rf.clr_busy_o = busy;
   assign rf.clr_done_o = done;

   // Without the FP bank, any address with the bank-select MSB set is unmapped.
   function automatic logic addr_ok(input logic msb);
      return HAS_FP || !msb;
   endfunction

   // Per-register write strobe/data; later ports overwrite earlier ones so the
   // highest-index enabled port wins. x0 is never decoded.
   always_comb begin
      wr_dec = '0;
      wr_dat = '0;
      if (!busy) begin
         for (int p = 0; p < NUM_WPORTS; p++) begin
            if (rf.we_i[p] && addr_ok(waddr[p][ADDR_WIDTH-1]) && waddr[p][IDX_W-1:0] != '0) begin
               wr_dec[waddr[p][IDX_W-1:0]] = 1'b1;
               wr_dat[waddr[p][IDX_W-1:0]] = wdata[p];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int r = 0; r < NUM_TOT; r++) mem[r] <= '0;
      end else begin
         for (int r = 0; r < NUM_TOT; r++) begin
            if (clr_stb && cnt_q == IDX_W'(r)) begin
               mem[r] <= '0;
            end else if (wr_dec[r]) begin
               mem[r] <= wr_dat[r];
            end
         end
      end
   end

   // Bypass is off during a clear; wr_dec is empty then anyway, and x0 is
   // never forwarded because wr_dec[0] is never set.
   assign byp_en = (BYPASS != 0) && !busy;

   always_comb begin
      for (int k = 0; k < NUM_RPORTS; k++) begin
         rd_idx[k] = raddr[k][IDX_W-1:0];
         rd_ok[k]  = addr_ok(raddr[k][ADDR_WIDTH-1]);
         rdata[k]  = '0;
         if (rd_ok[k]) begin
            if (byp_en && wr_dec[rd_idx[k]]) begin
               rdata[k] = wr_dat[rd_idx[k]];
            end else begin
               rdata[k] = mem[rd_idx[k]];
            end
         end
      end
   end

   assign alloc_vld = rf.alloc_i && !busy && addr_ok(rf.alloc_addr_i[ADDR_WIDTH-1]) &&
                      (rf.alloc_addr_i[IDX_W-1:0] != '0);

   // Clear engine: one register per cycle, then a single DONE cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      clr_stb = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (rf.clr_req_i) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
         end
         CLEAR: begin
            busy    = 1'b1;
            clr_stb = 1'b1;
            if (cnt_q == IDX_W'(NUM_TOT - 1)) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   cv32e40p_rf_scoreboard #(
      .NUM_TOT    (NUM_TOT),
      .NUM_RPORTS (NUM_RPORTS),
      .IDX_W      (IDX_W)
   ) u_scoreboard (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_dec    (wr_dec),
      .alloc_vld (alloc_vld),
      .alloc_idx (rf.alloc_addr_i[IDX_W-1:0]),
      .clr_stb   (clr_stb),
      .clr_idx   (cnt_q),
      .byp_en    (byp_en),
      .rd_idx    (rd_idx),
      .rd_ok     (rd_ok),
      .rbusy     (rf.rbusy_o)
   );

endmodule

// File: tb/tb_cv32e40p_regfile_mp.sv
// tb_cv32e40p_regfile_mp: random + directed bench for the register file against an array model.
// Two instances: FP bank present (FPU=1, ZFINX=0) and FP bank suppressed (ZFINX=1), both BYPASS=1.
module tb_cv32e40p_regfile_mp;
   localparam int AW = 6;
   localparam int DW = 32;
   localparam int NR = 3;
   localparam int NW = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cv32e40p_regfile_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RPORTS(NR), .NUM_WPORTS(NW)) rf_fp ();
   cv32e40p_regfile_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RPORTS(NR), .NUM_WPORTS(NW)) rf_zx ();

   cv32e40p_regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RPORTS(NR), .NUM_WPORTS(NW),
                         .FPU(1), .PULP_ZFINX(0), .BYPASS(1))
      u_fp (.clk(clk), .rst_n(rst_n), .rf(rf_fp));

   cv32e40p_regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RPORTS(NR), .NUM_WPORTS(NW),
                         .FPU(1), .PULP_ZFINX(1), .BYPASS(1))
      u_zx (.clk(clk), .rst_n(rst_n), .rf(rf_zx));

   int n_tests = 0;
   int n_fail  = 0;

   // stimulus for u_fp
   logic [AW-1:0] ra [NR];
   logic [AW-1:0] wa [NW];
   logic [DW-1:0] wd [NW];
   logic          we [NW];
   logic          alloc;
   logic [AW-1:0] aa;
   logic          creq;

   // sampled DUT outputs of the last cycle
   logic [DW-1:0] s_rdata [NR];
   logic          s_rbusy [NR];
   logic          s_busy, s_done;

   // reference model: 64 registers, pending flags, clear progress
   logic [DW-1:0] m_mem  [64];
   bit            m_pend [64];
   int            m_phase;   // 0 idle, 1 clearing, 2 done cycle
   int            m_pos;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < 64; r++) begin
         m_mem[r]  = '0;
         m_pend[r] = 1'b0;
      end
      m_phase = 0;
      m_pos   = 0;
   endtask

   task automatic clr_inputs();
      for (int k = 0; k < NR; k++) ra[k] = '0;
      for (int p = 0; p < NW; p++) begin
         wa[p] = '0;
         wd[p] = '0;
         we[p] = 1'b0;
      end
      alloc = 1'b0;
      aa    = '0;
      creq  = 1'b0;
   endtask

   task automatic drive();
      for (int k = 0; k < NR; k++) rf_fp.raddr_i[k*AW +: AW] = ra[k];
      for (int p = 0; p < NW; p++) begin
         rf_fp.waddr_i[p*AW +: AW] = wa[p];
         rf_fp.wdata_i[p*DW +: DW] = wd[p];
         rf_fp.we_i[p]             = we[p];
      end
      rf_fp.alloc_i      = alloc;
      rf_fp.alloc_addr_i = aa;
      rf_fp.clr_req_i    = creq;
   endtask

   function automatic bit written_now(input logic [AW-1:0] a);
      bit hit = 1'b0;
      for (int p = 0; p < NW; p++) if (we[p] && wa[p] == a && a != 0) hit = 1'b1;
      return hit;
   endfunction

   function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] a);
      logic [DW-1:0] v;
      v = (a == 0) ? '0 : m_mem[a];
      if (m_phase == 0 && a != 0)
         for (int p = 0; p < NW; p++) if (we[p] && wa[p] == a) v = wd[p];
      return v;
   endfunction

   function automatic logic exp_rbusy(input logic [AW-1:0] a);
      if (a == 0) return 1'b0;
      if (m_phase == 0 && written_now(a) && !(alloc && aa == a)) return 1'b0;
      return m_pend[a];
   endfunction

   task automatic model_update();
      if (m_phase == 0) begin
         for (int p = 0; p < NW; p++) begin
            if (we[p] && wa[p] != 0) begin
               m_mem[wa[p]]  = wd[p];
               m_pend[wa[p]] = 1'b0;
            end
         end
         if (alloc && aa != 0) m_pend[aa] = 1'b1;
         if (creq) begin
            m_phase = 1;
            m_pos   = 0;
         end
      end else if (m_phase == 1) begin
         m_mem[m_pos]  = '0;
         m_pend[m_pos] = 1'b0;
         m_pos++;
         if (m_pos == 64) m_phase = 2;
      end else begin
         m_phase = 0;
      end
   endtask

   // Called one time unit after a rising edge: apply inputs, check the
   // combinational outputs mid-cycle, then advance DUT and model together.
   task automatic cycle();
      drive();
      #3;
      for (int k = 0; k < NR; k++) begin
         s_rdata[k] = rf_fp.rdata_o[k*DW +: DW];
         s_rbusy[k] = rf_fp.rbusy_o[k];
         chk_eq($sformatf("rdata%0d a=%0d", k, ra[k]), s_rdata[k], exp_rdata(ra[k]));
         chk_eq($sformatf("rbusy%0d a=%0d", k, ra[k]), s_rbusy[k], exp_rbusy(ra[k]));
      end
      s_busy = rf_fp.clr_busy_o;
      s_done = rf_fp.clr_done_o;
      chk_eq("clr_busy", s_busy, m_phase != 0);
      chk_eq("clr_done", s_done, m_phase == 2);
      @(posedge clk);
      model_update();
      #1;
   endtask

   function automatic logic [AW-1:0] rand_addr();
      case ($urandom_range(0, 7))
         0: return 6'd0;
         1: return 6'd1;
         2: return 6'd7;
         3: return 6'd9;
         4: return 6'd31;
         5: return 6'd32;
         6: return 6'd35;
         default: return 6'd63;
      endcase
   endfunction

   task automatic rand_inputs(input bit with_creq);
      for (int k = 0; k < NR; k++) ra[k] = rand_addr();
      for (int p = 0; p < NW; p++) begin
         we[p] = 1'($urandom_range(0, 1));
         wa[p] = rand_addr();
         wd[p] = $urandom;
      end
      alloc = ($urandom_range(0, 3) == 0);
      aa    = rand_addr();
      creq  = with_creq;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nb, nd, done_at;

      model_reset();
      clr_inputs();
      drive();
      rf_zx.raddr_i = '0; rf_zx.waddr_i = '0; rf_zx.wdata_i = '0; rf_zx.we_i = '0;
      rf_zx.alloc_i = 1'b0; rf_zx.alloc_addr_i = '0; rf_zx.clr_req_i = 1'b0;

      // reset state: x5, f3 read zero, nothing busy
      #22;
      ra[0] = 6'd5; ra[1] = 6'd35; ra[2] = 6'd0;
      drive();
      #1;
      chk_eq("rst_rd_x5", rf_fp.rdata_o[31:0], 32'h0);
      chk_eq("rst_rd_f3", rf_fp.rdata_o[63:32], 32'h0);
      chk_eq("rst_rbusy", rf_fp.rbusy_o, 3'b000);
      chk_eq("rst_clr_busy", rf_fp.clr_busy_o, 1'b0);
      chk_eq("rst_clr_done", rf_fp.clr_done_o, 1'b0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      cycle();
      chk_eq("idle_rd_x5", s_rdata[0], 32'h0);
      chk_eq("idle_rd_f3", s_rdata[1], 32'h0);

      // both ports write x7: port1 wins, bypassed then stored
      clr_inputs();
      we[0] = 1'b1; wa[0] = 6'd7; wd[0] = 32'h11111111;
      we[1] = 1'b1; wa[1] = 6'd7; wd[1] = 32'h22222222;
      ra[0] = 6'd7;
      cycle();
      chk_eq("byp_x7", s_rdata[0], 32'h22222222);
      clr_inputs(); ra[0] = 6'd7;
      cycle();
      chk_eq("stored_x7", s_rdata[0], 32'h22222222);

      // x0 never written nor forwarded
      clr_inputs();
      we[1] = 1'b1; wa[1] = 6'd0; wd[1] = 32'hDEADBEEF;
      cycle();
      chk_eq("x0_same_cyc", s_rdata[0], 32'h0);
      chk_eq("x0_rbusy", s_rbusy[0], 1'b0);
      clr_inputs();
      cycle();
      chk_eq("x0_next_cyc", s_rdata[0], 32'h0);

      // alloc x9 -> busy next cycle; write clears it with bypass in the same cycle
      clr_inputs(); alloc = 1'b1; aa = 6'd9; ra[0] = 6'd9;
      cycle();
      clr_inputs(); ra[0] = 6'd9;
      cycle();
      chk_eq("alloc_x9_busy", s_rbusy[0], 1'b1);
      clr_inputs(); ra[0] = 6'd9; we[0] = 1'b1; wa[0] = 6'd9; wd[0] = 32'hA5A5A5A5;
      cycle();
      chk_eq("wr_x9_rbusy_byp", s_rbusy[0], 1'b0);
      chk_eq("wr_x9_rdata_byp", s_rdata[0], 32'hA5A5A5A5);
      clr_inputs(); ra[0] = 6'd9;
      cycle();
      chk_eq("x9_stored", s_rdata[0], 32'hA5A5A5A5);
      chk_eq("x9_not_busy", s_rbusy[0], 1'b0);

      // alloc + write to x9 together: pending stays set, data commits
      clr_inputs(); ra[0] = 6'd9; alloc = 1'b1; aa = 6'd9;
      we[0] = 1'b1; wa[0] = 6'd9; wd[0] = 32'h0000005A;
      cycle();
      clr_inputs(); ra[0] = 6'd9;
      cycle();
      chk_eq("alloc_wr_busy", s_rbusy[0], 1'b1);
      chk_eq("alloc_wr_data", s_rdata[0], 32'h0000005A);

      // Zfinx instance: 0x23 is unmapped, must not alias onto x3
      rf_zx.we_i = 2'b11;
      rf_zx.waddr_i = {6'd3, 6'h23};
      rf_zx.wdata_i = {32'h00000033, 32'h12345678};
      rf_zx.raddr_i = {6'd0, 6'd3, 6'h23};
      #3;
      chk_eq("zx_byp_23", rf_zx.rdata_o[31:0], 32'h0);
      chk_eq("zx_byp_x3", rf_zx.rdata_o[63:32], 32'h00000033);
      @(posedge clk); #1;
      rf_zx.we_i = 2'b00; rf_zx.alloc_i = 1'b1; rf_zx.alloc_addr_i = 6'h23;
      #3;
      chk_eq("zx_rd_23", rf_zx.rdata_o[31:0], 32'h0);
      chk_eq("zx_rd_x3", rf_zx.rdata_o[63:32], 32'h00000033);
      @(posedge clk); #1;
      rf_zx.alloc_i = 1'b0;
      #3;
      chk_eq("zx_alloc23_rbusy", rf_zx.rbusy_o, 3'b000);
      @(posedge clk); #1;

      // randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         rand_inputs($urandom_range(0, 399) == 0);
         cycle();
      end
      clr_inputs();
      for (int i = 0; i < 80 && m_phase != 0; i++) cycle();

      // fill all 63 writable registers, some also pending
      for (int a = 1; a < 64; a += 2) begin
         clr_inputs();
         we[0] = 1'b1; wa[0] = AW'(a); wd[0] = $urandom | 32'h1;
         if (a + 1 < 64) begin
            we[1] = 1'b1; wa[1] = AW'(a + 1); wd[1] = $urandom | 32'h1;
         end
         alloc = (a % 4 == 1); aa = AW'(a);
         cycle();
      end

      // bulk clear with writes/allocs/requests hammered during it
      clr_inputs(); creq = 1'b1;
      cycle();
      nb = 0; nd = 0; done_at = 0;
      for (int i = 0; i < 70; i++) begin
         clr_inputs();
         if (i < 65) rand_inputs(1'b1);
         else for (int k = 0; k < NR; k++) ra[k] = rand_addr();
         cycle();
         if (s_busy) nb++;
         if (s_done) begin
            nd++;
            done_at = nb;
         end
      end
      chk_eq("clr_busy_len", nb, 65);
      chk_eq("clr_done_cnt", nd, 1);
      chk_eq("clr_done_at", done_at, 65);
      for (int a = 0; a < 64; a += NR) begin
         clr_inputs();
         for (int k = 0; k < NR; k++) ra[k] = AW'(a + k);
         cycle();
         for (int k = 0; k < NR; k++) begin
            chk_eq("post_clr_rdata", s_rdata[k], 32'h0);
            chk_eq("post_clr_rbusy", s_rbusy[k], 1'b0);
         end
      end

      // reset during clear cycle 20
      clr_inputs();
      we[0] = 1'b1; wa[0] = 6'd40; wd[0] = 32'hCAFE0040;
      we[1] = 1'b1; wa[1] = 6'd63; wd[1] = 32'hCAFE0063;
      alloc = 1'b1; aa = 6'd50;
      cycle();
      clr_inputs(); creq = 1'b1;
      cycle();
      clr_inputs(); ra[0] = 6'd40; ra[1] = 6'd63; ra[2] = 6'd50;
      repeat (20) cycle();
      chk_eq("pre_rst_busy", s_busy, 1'b1);
      chk_eq("pre_rst_x40", s_rdata[0], 32'hCAFE0040);
      rst_n = 1'b0;
      #1;
      chk_eq("midclr_rst_busy", rf_fp.clr_busy_o, 1'b0);
      chk_eq("midclr_rst_done", rf_fp.clr_done_o, 1'b0);
      chk_eq("midclr_rst_x40", rf_fp.rdata_o[31:0], 32'h0);
      chk_eq("midclr_rst_rbusy", rf_fp.rbusy_o, 3'b000);
      model_reset();
      #2;
      rst_n = 1'b1;
      nd = 0;
      for (int i = 0; i < 70; i++) begin
         cycle();
         if (s_done) nd++;
      end
      chk_eq("no_done_after_rst", nd, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/cv32e40p_regfile_mp.md
Name: cv32e40p_regfile_mp

Overview:
- Parametrised flip-flop register file for the cv32e40p ID stage: configurable read/write port count, optional FP bank and same-cycle write-to-read bypass.
- Adds a per-register pending scoreboard for long-latency producers (LSU, FPU, divider).
- Adds a sequential bulk-clear engine for debug/secure-context reset.

Parameters:
- ADDR_WIDTH, 6, address bits; MSB selects FP bank, low 5 bits select the register.
- DATA_WIDTH, 32, register width.
- NUM_RPORTS, 3, read ports.
- NUM_WPORTS, 2, write ports; higher index has higher priority.
- FPU, 0, 1 instantiates the 32-entry FP bank.
- PULP_ZFINX, 0, 1 suppresses the FP bank even when FPU=1.
- BYPASS, 1, 1 forwards same-cycle write data to matching reads.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- raddr_i  in  NUM_RPORTS*ADDR_WIDTH  read addresses.
- rdata_o  out  NUM_RPORTS*DATA_WIDTH  read data, combinational.
- rbusy_o  out  NUM_RPORTS  addressed register pending.
- waddr_i  in  NUM_WPORTS*ADDR_WIDTH  write addresses.
- wdata_i  in  NUM_WPORTS*DATA_WIDTH  write data.
- we_i  in  NUM_WPORTS  write enables.
- alloc_i  in  1  mark alloc_addr_i pending.
- alloc_addr_i  in  ADDR_WIDTH  register to mark pending.
- clr_req_i  in  1  start bulk clear.
- clr_busy_o  out  1  clear in progress.
- clr_done_o  out  1  one-cycle pulse when clear completes.

Behaviour:
- Banks and reset:
  - Integer bank: 32 entries; x0 (addr 0) reads 0, is never written and is never pending.
  - FP bank exists iff FPU=1 && PULP_ZFINX=0; NUM_TOT = 64, else 32.
  - Without the FP bank, MSB=1 reads return 0 and MSB=1 writes/allocs are dropped.
  - Reset: all registers 0, all pending bits 0, FSM IDLE, clr_busy_o=0, clr_done_o=0, rbusy_o=0, rdata_o=0.
- Writes:
  - Commit at posedge.
  - Several ports writing the same address: highest-index enabled port wins.
- Reads:
  - Zero latency.
  - BYPASS=1 and an enabled write targets the read address: rdata = winning port's wdata.
  - BYPASS=1 and the address is x0: rdata = 0, never forwarded.
  - BYPASS=0: rdata = stored value.
- Scoreboard:
  - alloc_i sets pending[alloc_addr_i] at next edge.
  - Any committed write clears that register's pending bit.
  - Alloc and write to the same register in the same cycle: pending ends 1 (new producer wins); the write data still commits.
  - rbusy_o[k] = pending[raddr_k], except with BYPASS=1 it is 0 when a same-cycle write to that address exists and no alloc targets that address.
- Clear FSM:
  - States IDLE, CLEAR, DONE; a counter cnt of log2(NUM_TOT) bits.
  - IDLE: clr_req_i=1 -> CLEAR, cnt=0.
  - CLEAR: each cycle zero mem[cnt] and pending[cnt]; cnt=NUM_TOT-1 -> DONE; otherwise cnt++. Duration is NUM_TOT cycles.
  - DONE: clr_done_o=1 for that single cycle -> IDLE.
  - clr_busy_o=1 in CLEAR and DONE.
  - During CLEAR/DONE all writes and allocs are ignored; reads return current contents and bypass is disabled.
  - clr_req_i is ignored outside IDLE.
  - rst_n low mid-clear: immediate return to IDLE with reset values; no clr_done_o.

Decomposition:
- Package cv32e40p_rf_pkg:
  - clr_state_e {IDLE, CLEAR, DONE}.
  - Localparams NUM_INT_WORDS=32 and NUM_FP_WORDS=32.
  - Function rf_num_tot(FPU, PULP_ZFINX).
- Sub-module cv32e40p_rf_scoreboard:
  - Owns the pending vector, alloc/clear/write-clear priority and rbusy computation.
  - Takes the per-register write-decode vector and the clear-index strobe.

Test Plan:
- Reset, then read x5, f3 -> rdata 0, rbusy 0, clr_busy 0.
- Same cycle: port0 writes x7=0x11111111, port1 writes x7=0x22222222, BYPASS=1 -> same-cycle read x7 = 0x22222222; next cycle stored x7 = 0x22222222.
- Write x0=0xDEADBEEF on port1 with read x0 -> rdata 0 both cycles; rbusy 0.
- alloc x9 -> next cycle rbusy=1.
- Following the x9 alloc: write x9=0xA5A5A5A5 on port0 -> rbusy=0 in that same cycle (BYPASS=1) and the value is readable.
- alloc x9 + write x9 in the same cycle -> pending stays 1.
- FPU=1, PULP_ZFINX=0: fill all 63 writable registers with nonzero values, pulse clr_req_i -> clr_busy high for 65 cycles, clr_done pulses once at cycle 65, all reads 0, all rbusy 0.
- Writes issued during the clear are dropped.
- Deassert rst_n at clear cycle 20 -> immediate IDLE, clr_busy 0, no clr_done pulse.
- PULP_ZFINX=1: write addr 0x23 -> ignored; read 0x23 returns 0.
